// File: rtl/stream_mux.sv
// stream_mux: NUM_CH-to-1 stream mux with fixed/round-robin grant and a registered output stage.
// Define STREAM_MUX_XFER_CNT_EN to add the 16-bit xfer_cnt output transfer counter.
module stream_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 16,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef STREAM_MUX_XFER_CNT_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;
  logic             w_can_load;
  logic             w_fx_hit;
  logic             w_rr_hit;
  logic [SEL_W-1:0] w_rr_g;
  logic             w_hit;
  logic [SEL_W-1:0] w_g;
  logic [WIDTH-1:0] w_data;
  logic             w_xfer_in;
  assign w_can_load = !r_out_valid || out_ready;
  assign w_fx_hit   = int'(sel) < NUM_CH;
  // Scan downward so the nearest valid channel after r_rr_ptr is the last one written.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_g   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (in_valid[(int'(r_rr_ptr) + k) % NUM_CH]) begin
        w_rr_hit = 1'b1;
        w_rr_g   = SEL_W'((int'(r_rr_ptr) + k) % NUM_CH);
      end
    end
  end
  assign w_hit     = mode ? w_rr_hit : w_fx_hit;
  assign w_g       = mode ? w_rr_g : sel;
  assign in_ready  = (rst_n && w_hit && w_can_load) ? (NUM_CH'(1) << w_g) : '0;
  assign w_xfer_in = |(in_ready & in_valid);
  assign w_data    = in_data[int'(w_g)*WIDTH +: WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer_in) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      if (mode) r_rr_ptr <= w_g;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
`ifdef STREAM_MUX_XFER_CNT_EN
  logic [15:0] r_xfer_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_xfer_cnt <= '0;
    else if (r_out_valid && out_ready) r_xfer_cnt <= r_xfer_cnt + 16'd1;
  end
  assign xfer_cnt = r_xfer_cnt;
`endif
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed vector table plus hand sequences for round-robin, backpressure and reset.
module tb_stream_mux;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data;
  logic [15:0]  in_valid;
  logic [15:0]  in_ready;
  logic [3:0]   sel;
  logic         mode;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [39:0]  in_data5;
  logic [4:0]   in_valid5;
  logic [4:0]   in_ready5;
  logic [2:0]   sel5;
  logic         mode5;
  logic [7:0]   out_data5;
  logic         out_valid5;
  logic         out_ready5;
  logic [7:0]   d [16];
  int           n_chk = 0;
  int           n_err = 0;
`ifdef STREAM_MUX_XFER_CNT_EN
  logic [15:0]  xfer_cnt;
  logic [15:0]  xfer_cnt5;
  int           n_xfer = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n_xfer = 0;
    else if (out_valid && out_ready) n_xfer = n_xfer + 1;
`endif

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(8), .NUM_CH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  stream_mux #(.WIDTH(8), .NUM_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .sel(sel5), .mode(mode5), .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef STREAM_MUX_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt5)
`endif
  );

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] vld;
    logic        ordy;
    logic [15:0] exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) d[i] = 8'(8'h40 + i);
    d[3] = 8'hA5;
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = d[i];
    in_data5   = 40'h1122334455;
    in_valid5  = 5'b11111;
    sel5       = 3'd6;
    mode5      = 1'b0;
    out_ready5 = 1'b1;
    in_valid   = 16'hFFFF;
    sel        = 4'd0;
    mode       = 1'b0;
    out_ready  = 1'b1;
    // mode, sel, valid, out_ready, expected in_ready, expected out_valid/out_data after the edge
    tv[0]  = '{1'b0, 4'd3, 16'h0008, 1'b1, 16'h0008, 1'b1, 8'hA5};
    tv[1]  = '{1'b0, 4'd5, 16'h0000, 1'b1, 16'h0020, 1'b0, 8'hA5};
    tv[2]  = '{1'b0, 4'd5, 16'h0020, 1'b0, 16'h0020, 1'b1, 8'h45};
    tv[3]  = '{1'b0, 4'd7, 16'h0080, 1'b0, 16'h0000, 1'b1, 8'h45};
    tv[4]  = '{1'b1, 4'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h45};
    tv[5]  = '{1'b1, 4'd0, 16'h0006, 1'b1, 16'h0002, 1'b1, 8'h41};
    tv[6]  = '{1'b1, 4'd0, 16'h0006, 1'b1, 16'h0004, 1'b1, 8'h42};
    tv[7]  = '{1'b1, 4'd0, 16'h0006, 1'b1, 16'h0002, 1'b1, 8'h41};
    tv[8]  = '{1'b1, 4'd0, 16'h8001, 1'b1, 16'h8000, 1'b1, 8'h4F};
    tv[9]  = '{1'b0, 4'd2, 16'h8001, 1'b1, 16'h0004, 1'b0, 8'h4F};
    tv[10] = '{1'b1, 4'd0, 16'h8001, 1'b1, 16'h0001, 1'b1, 8'h40};
    tv[11] = '{1'b1, 4'd0, 16'h8001, 1'b0, 16'h0000, 1'b1, 8'h40};

    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    #10;
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      mode = tv[v].mode;
      sel = tv[v].sel;
      in_valid = tv[v].vld;
      out_ready = tv[v].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(tv[v].exp_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(tv[v].exp_ov));
      chk($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(tv[v].exp_od));
    end

    // Full round-robin sweep starting from a fresh reset
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    mode = 1'b1;
    in_valid = 16'hFFFF;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      chk($sformatf("rr%0d_in_ready", k), 32'(in_ready), 32'(16'h1 << (k % 16)));
      tick();
      chk($sformatf("rr%0d_out_data", k), 32'(out_data), 32'(d[k % 16]));
    end

    // Backpressure: ch0 word held, grant withheld, then ch1 follows
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_out_data", k), 32'(out_data), 32'(d[0]));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'h0002);
    tick();
    chk("bp_release_out_data", 32'(out_data), 32'(d[1]));
    chk("bp_release_out_valid", 32'(out_valid), 32'd1);

    // Reset mid-transfer clears the held word without a clock edge
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("rst_held_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(in_ready), 32'h0001);
    tick();
    chk("post_rst_out_data", 32'(out_data), 32'(d[0]));

    // Five-channel instance with an out-of-range fixed select
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("nch5_%0d_in_ready", k), 32'(in_ready5), 32'd0);
      tick();
      chk($sformatf("nch5_%0d_out_valid", k), 32'(out_valid5), 32'd0);
    end

`ifdef STREAM_MUX_XFER_CNT_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(n_xfer[15:0]));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each channel's data.
REQ-002 Parameter NUM_CH, default 16, number of input channels (2..64); SEL_W = clog2(NUM_CH).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  NUM_CH  per-channel valid.
REQ-007 in_ready  output  NUM_CH  per-channel ready; one-hot or zero.
REQ-008 sel  input  SEL_W  channel select in fixed mode.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data holds an untaken word.
REQ-012 out_ready  input  1  downstream accepts out_data when high with out_valid.

Function
REQ-013 Output register "can load" = !out_valid || out_ready, evaluated in the same cycle.
REQ-014 Grant is combinational: the granted channel g has in_ready[g] = can_load; all other in_ready bits are 0.
REQ-015 Transfer in on channel g = in_valid[g] && in_ready[g]; on that edge out_data <= channel g data and out_valid <= 1; latency 1 cycle.
REQ-016 If out_valid && out_ready and no input transfer occurs, out_valid <= 0 and out_data holds its value.
REQ-017 Simultaneous drain and load in one cycle yields a back-to-back transfer; sustained throughput is 1 word/cycle.
REQ-018 Fixed mode: grant candidate = sel; if sel >= NUM_CH, no channel is granted and all in_ready bits are 0.
REQ-019 Round-robin mode: the grant is the first channel with in_valid set, searching from rr_ptr+1 upward and wrapping modulo NUM_CH, ending at rr_ptr itself.
REQ-020 rr_ptr (SEL_W bits) updates to g only on an input transfer; it does not change in fixed mode or when can_load = 0.
REQ-021 A channel whose data is not taken keeps its priority; grant is not withdrawn mid-stall (rr_ptr frozen while can_load = 0).
REQ-022 A mode change takes effect on the next grant evaluation; rr_ptr is preserved across mode changes.
REQ-023 No input valid in round-robin mode: no grant, all in_ready bits are 0, rr_ptr unchanged.
REQ-024 out_data and out_valid are stable while out_valid && !out_ready.

Reset
REQ-025 While rst_n = 0: out_valid = 0, out_data = 0, rr_ptr = NUM_CH-1 (so channel 0 wins the first round-robin search), transfer count = 0.
REQ-026 Reset asserted mid-transfer discards the held word immediately; in_ready is 0 for every channel during reset.
REQ-027 Reset deassertion is synchronised externally; the block requires no post-reset idle cycles.

Configuration
REQ-028 Macro STREAM_MUX_XFER_CNT_EN defined: adds output port xfer_cnt (output, 16 bits), incremented on each output transfer (out_valid && out_ready), wrapping 0xFFFF -> 0x0000.
REQ-029 Macro STREAM_MUX_XFER_CNT_EN undefined: the xfer_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-030 Reset, then mode=0, sel=3, in_valid[3]=1, data3=0xA5, out_ready=1 -> in_ready=0x0008; one cycle later out_valid=1, out_data=0xA5.
REQ-031 mode=1, all 16 valids high, out_ready=1 for 17 cycles -> grants in order 0,1,...,15,0; out_data matches each channel's data one cycle later.
REQ-032 Backpressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data unchanged, rr_ptr unchanged; on out_ready=1, the next channel transfers with no lost or duplicated word.
REQ-033 NUM_CH=5, mode=0, sel=6 with all valids high -> in_ready=0 and out_valid stays 0.
REQ-034 Reset pulsed while out_valid=1 -> out_valid=0 and out_data=0 asynchronously; the first round-robin grant after release is channel 0.
REQ-035 With STREAM_MUX_XFER_CNT_EN defined, 65537 output transfers -> xfer_cnt=1.
